gpio_bank_avl: RTL and testbench

GPIO_BANK_AVL -- requirements
Module: gpio_bank_avl

---
 rtl/gpio_bank_avl.sv | 137 +++++++++++++
 tb/tb_gpio_bank_avl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank_avl.sv
// gpio_bank_avl: Avalon-MM slave controlling NUM_PORTS banks of WIDTH GPIO pins.
//
// Ports
//   clk_clk            sole clock, rising edge
//   reset_reset_n      asynchronous active-low reset
//   avs_address[5:0]   word address {port[5:3], reg[2:0]}
//   avs_read/avs_write read / write strobes (write wins when both are high)
//   avs_writedata      write data (bits >= WIDTH ignored)
//   avs_readdata       read data, valid with avs_readdatavalid, 0 otherwise
//   avs_readdatavalid  high one cycle after each accepted read
//   gpio_in            asynchronous pin inputs, port p at [p*WIDTH +: WIDTH]
//   gpio_out/gpio_oe   pin output data / output enable (1 = drive)
//   irq                registered level interrupt, active-high
//
// Per-port registers: 0 DATA_IN, 1 DATA_OUT, 2 DIR, 3 OUT_SET, 4 OUT_CLR,
// 5 EDGE_CAP (W1C), 6 IRQ_MASK, 7 EDGE_POL (0 rising, 1 falling).
module gpio_bank_avl #(
    parameter int NUM_PORTS   = 3,
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset_n,
    input  logic [5:0]                 avs_address,
    input  logic                       avs_read,
    input  logic                       avs_write,
    input  logic [31:0]                avs_writedata,
    output logic [31:0]                avs_readdata,
    output logic                       avs_readdatavalid,
    input  logic [NUM_PORTS*WIDTH-1:0] gpio_in,
    output logic [NUM_PORTS*WIDTH-1:0] gpio_out,
    output logic [NUM_PORTS*WIDTH-1:0] gpio_oe,
    output logic                       irq
);

    localparam int N = NUM_PORTS * WIDTH;

    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0] prev_q, sync_s, edge_det;
    logic [N-1:0] dout_q, dout_d, dir_q, dir_d, cap_q, cap_d, cap_clr;
    logic [N-1:0] mask_q, mask_d, pol_q, pol_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         rvalid_q, irq_q;
    logic [2:0]   port_a, reg_a;
    logic [WIDTH-1:0] wd, rd_word;
    logic         wr_en, rd_en;

    assign port_a = avs_address[5:3];
    assign reg_a  = avs_address[2:0];
    assign wd     = avs_writedata[WIDTH-1:0];
    assign wr_en  = avs_write;
    // A simultaneous read+write is treated purely as a write.
    assign rd_en  = avs_read & ~avs_write;

    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign edge_det = (pol_q & ~sync_s & prev_q) | (~pol_q & sync_s & ~prev_q);

    // Register writes; ports >= NUM_PORTS never match and are dropped.
    always_comb begin
        dout_d  = dout_q;
        dir_d   = dir_q;
        mask_d  = mask_q;
        pol_d   = pol_q;
        cap_clr = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (wr_en && port_a == 3'(p)) begin
                case (reg_a)
                    3'd1: dout_d[p*WIDTH +: WIDTH] = wd;
                    3'd2: dir_d[p*WIDTH +: WIDTH]  = wd;
                    3'd3: dout_d[p*WIDTH +: WIDTH] = dout_q[p*WIDTH +: WIDTH] | wd;
                    3'd4: dout_d[p*WIDTH +: WIDTH] = dout_q[p*WIDTH +: WIDTH] & ~wd;
                    3'd5: cap_clr[p*WIDTH +: WIDTH] = wd;
                    3'd6: mask_d[p*WIDTH +: WIDTH] = wd;
                    3'd7: pol_d[p*WIDTH +: WIDTH]  = wd;
                    default: ;
                endcase
            end
        end
        // OR-ing the new edge in after the clear lets a same-cycle edge win.
        cap_d = (cap_q & ~cap_clr) | edge_det;
    end

    // Read mux; write-only registers and absent ports return 0.
    always_comb begin
        rd_word = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_a == 3'(p)) begin
                case (reg_a)
                    3'd0: rd_word = sync_s[p*WIDTH +: WIDTH];
                    3'd1: rd_word = dout_q[p*WIDTH +: WIDTH];
                    3'd2: rd_word = dir_q[p*WIDTH +: WIDTH];
                    3'd5: rd_word = cap_q[p*WIDTH +: WIDTH];
                    3'd6: rd_word = mask_q[p*WIDTH +: WIDTH];
                    3'd7: rd_word = pol_q[p*WIDTH +: WIDTH];
                    default: rd_word = '0;
                endcase
            end
        end
        rdata_d = rd_en ? 32'(rd_word) : 32'd0;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync_q   <= '0;
            prev_q   <= '0;
            dout_q   <= '0;
            dir_q    <= '0;
            cap_q    <= '0;
            mask_q   <= '0;
            pol_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q   <= sync_s;
            dout_q   <= dout_d;
            dir_q    <= dir_d;
            cap_q    <= cap_d;
            mask_q   <= mask_d;
            pol_q    <= pol_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rd_en;
            irq_q    <= |(cap_q & mask_q);
        end
    end

    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign gpio_out          = dout_q;
    assign gpio_oe           = dir_q;
    assign irq               = irq_q;

endmodule

// File: tb/tb_gpio_bank_avl.sv
// Scoreboard bench for gpio_bank_avl (NUM_PORTS=3, WIDTH=32, SYNC_STAGES=2).
// Reads push {expected data, expected valid cycle} into a queue; a negedge
// monitor pops an entry whenever avs_readdatavalid is seen and compares.
module tb_gpio_bank_avl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  avs_address = '0;
    logic        avs_read = 1'b0, avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [95:0] gpio_in = '0;
    logic [95:0] gpio_out, gpio_oe;
    logic        irq;

    gpio_bank_avl #(.NUM_PORTS(3), .WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every readdatavalid must match the oldest expected read.
    always @(negedge clk) begin
        if (avs_readdatavalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_readdatavalid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_data"}, avs_readdata, e.data);
                chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
        end else begin
            chk("readdata_idle_zero", avs_readdata, 0);
        end
    end

    function automatic logic [5:0] a(input int port, input int r);
        return {3'(port), 3'(r)};
    endfunction

    task automatic wr(input logic [5:0] ad, input logic [31:0] d);
        avs_address = ad; avs_writedata = d; avs_write = 1'b1;
        @(posedge clk); #1;
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [5:0] ad, input logic [31:0] d, input string name);
        exp_t e;
        e.data = d; e.cyc = cyc + 1; e.name = name;
        sb.push_back(e);
        avs_address = ad; avs_read = 1'b1;
        @(posedge clk); #1;
        avs_read = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk("rst_gpio_out", gpio_out, 0);
        chk("rst_gpio_oe", gpio_oe, 0);
        chk("rst_irq", irq, 0);
        chk("rst_rdv", avs_readdatavalid, 0);
        rst_n = 1'b1;
        tick(1);

        // Output data / direction on port1
        wr(a(1,1), 32'hA5A5_0000);
        wr(a(1,2), 32'hFFFF_0000);
        chk("p1_gpio_out", gpio_out[63:32], 32'hA5A5_0000);
        chk("p1_gpio_oe", gpio_oe[63:32], 32'hFFFF_0000);

        // Set/clear on port0 DATA_OUT: 0xF0 | 0x0F = 0xFF, & ~0x30 = 0xCF
        wr(a(0,1), 32'h0000_00F0);
        wr(a(0,3), 32'h0000_000F);
        wr(a(0,4), 32'h0000_0030);
        rd(a(0,1), 32'h0000_00CF, "setclr_readback");
        rd(a(1,2), 32'hFFFF_0000, "p1_dir");
        rd(a(0,3), 32'h0, "out_set_wo");
        rd(a(0,4), 32'h0, "out_clr_wo");

        // Rising edge on port0 pin3 with mask bit3
        wr(a(0,6), 32'h8);
        gpio_in[3] = 1'b1;
        tick(2);
        rd(a(0,0), 32'h8, "data_in_bit3");
        chk("irq_not_yet", irq, 0);
        tick(1);
        chk("irq_set", irq, 1);
        rd(a(0,5), 32'h8, "edge_cap_rise");
        wr(a(0,5), 32'h8);
        chk("irq_still_1_after_w1c", irq, 1);
        tick(1);
        chk("irq_cleared", irq, 0);

        // Falling polarity on pin0; rise ignored, fall captured even
        // when a W1C of the same bit lands in the same cycle.
        wr(a(0,7), 32'h1);
        gpio_in[0] = 1'b1;
        tick(4);
        rd(a(0,5), 32'h0, "rise_ignored_pol1");
        gpio_in[0] = 1'b0;
        tick(2);
        wr(a(0,5), 32'h1);
        rd(a(0,5), 32'h1, "fall_beats_w1c");
        chk("irq_unmasked_bit0", irq, 0);
        wr(a(0,5), 32'h1);
        rd(a(0,5), 32'h0, "w1c_clears");

        // Read+write together acts as a write only
        avs_address = a(2,1); avs_writedata = 32'h0000_1234;
        avs_read = 1'b1; avs_write = 1'b1;
        @(posedge clk); #1;
        avs_read = 1'b0; avs_write = 1'b0;
        rd(a(2,1), 32'h0000_1234, "rw_is_write");

        // Absent port reads 0, writes dropped
        rd(a(5,1), 32'h0, "port5_read");
        wr(a(5,1), 32'hFFFF_FFFF);
        wr(a(5,2), 32'hFFFF_FFFF);
        chk("port5_write_ignored", gpio_out, {32'h0000_1234, 32'hA5A5_0000, 32'h0000_00CF});
        chk("port5_dir_ignored", gpio_oe, {32'h0, 32'hFFFF_0000, 32'h0});

        // Reset while a read response is pending
        avs_address = a(0,1); avs_read = 1'b1;
        @(posedge clk); #1;
        avs_read = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrd_gpio_out", gpio_out, 0);
        chk("midrd_gpio_oe", gpio_oe, 0);
        chk("midrd_irq", irq, 0);
        chk("midrd_rdata", avs_readdata, 0);
        chk("midrd_rdv", avs_readdatavalid, 0);
        tick(2);
        rst_n = 1'b1;
        // pin3 still high: prev cleared by reset gives one rising edge
        tick(4);
        rd(a(0,5), 32'h8, "edge_after_reset");
        rd(a(0,1), 32'h0, "dout_after_reset");
        chk("irq_after_reset_masked", irq, 0);
        tick(3);

        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
